// File: rtl/cmos_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmos_pkg : shared state encoding and sizing helpers for the CMOS      |
// |            sensor power/reset sequencer                               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package cmos_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_PWDN_HOLD = 3'd1,
    ST_RST_HOLD  = 3'd2,
    ST_BOOT_WAIT = 3'd3,
    ST_CONFIG    = 3'd4,
    ST_RUN       = 3'd5,
    ST_ERR       = 3'd6
  } state_t;

  // Width of a counter that must reach (largest limit - 1).
  function automatic int cnt_w(input int unsigned a, input int unsigned b,
                               input int unsigned c, input int unsigned d,
                               input int unsigned e);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmos_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmos_sync2 : two-flop synchronizer, async active-low reset to 0       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module cmos_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      q      <= 1'b0;
    end else begin
      r_meta <= d;
      q      <= r_meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cmos_pwr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmos_pwr_seq : PLL-lock gated power-up / reset / config sequencer     |
// |                for an OV-series CMOS sensor                           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module cmos_pwr_seq
  import cmos_pkg::*;
#(
  parameter int unsigned LOCK_FILT_CYC   = 1024,
  parameter int unsigned PWDN_CYC        = 250000,
  parameter int unsigned RST_CYC         = 50000,
  parameter int unsigned BOOT_CYC        = 1000000,
  parameter int unsigned CFG_TIMEOUT_CYC = 5000000,
  parameter int unsigned MAX_RETRY       = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_lock,
  input  logic               cfg_done,
  output logic               cmos_pwdn,
  output logic               cmos_rst_n,
  output logic               cfg_start,
  output logic               sys_rst_n,
  output logic               seq_ready,
  output logic               seq_err,
  output logic [STATE_W-1:0] state_o
);

  localparam int CNT_W   = cnt_w(LOCK_FILT_CYC, PWDN_CYC, RST_CYC, BOOT_CYC, CFG_TIMEOUT_CYC);
  localparam int RETRY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY);

  localparam logic [CNT_W-1:0]   c_lock_last  = CNT_W'(LOCK_FILT_CYC - 1);
  localparam logic [CNT_W-1:0]   c_pwdn_last  = CNT_W'(PWDN_CYC - 1);
  localparam logic [CNT_W-1:0]   c_rst_last   = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0]   c_boot_last  = CNT_W'(BOOT_CYC - 1);
  localparam logic [CNT_W-1:0]   c_cfg_last   = CNT_W'(CFG_TIMEOUT_CYC - 1);
  localparam logic [RETRY_W-1:0] c_retry_last = RETRY_W'(MAX_RETRY - 1);

  logic               w_lock_s;
  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [RETRY_W-1:0] r_retry;
  logic [RETRY_W-1:0] w_retry_next;

  cmos_sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (w_lock_s)
  );

  always_comb begin
    w_next       = r_state;
    w_retry_next = r_retry;
    case (r_state)
      ST_WAIT_LOCK: if (w_lock_s && r_cnt == c_lock_last) w_next = ST_PWDN_HOLD;
      ST_PWDN_HOLD: if (r_cnt == c_pwdn_last) w_next = ST_RST_HOLD;
      ST_RST_HOLD:  if (r_cnt == c_rst_last)  w_next = ST_BOOT_WAIT;
      ST_BOOT_WAIT: if (r_cnt == c_boot_last) w_next = ST_CONFIG;
      ST_CONFIG: begin
        // A cfg_done coinciding with the timeout edge still counts as success.
        if (cfg_done) begin
          w_next       = ST_RUN;
          w_retry_next = '0;
        end else if (r_cnt == c_cfg_last) begin
          if (r_retry == c_retry_last) begin
            w_next = ST_ERR;
          end else begin
            w_next       = ST_RST_HOLD;
            w_retry_next = r_retry + 1'b1;
          end
        end
      end
      ST_RUN:  w_next = ST_RUN;
      ST_ERR:  w_next = ST_ERR;
      default: w_next = ST_WAIT_LOCK;
    endcase

    // Lock loss overrides everything except ERR; retry history survives it.
    if (!w_lock_s && r_state != ST_WAIT_LOCK && r_state != ST_ERR) begin
      w_next       = ST_WAIT_LOCK;
      w_retry_next = r_retry;
    end

    if (w_next != r_state || r_state == ST_RUN || r_state == ST_ERR ||
        (r_state == ST_WAIT_LOCK && !w_lock_s)) begin
      w_cnt_next = '0;
    end else begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_WAIT_LOCK;
      r_cnt      <= '0;
      r_retry    <= '0;
      cmos_pwdn  <= 1'b1;
      cmos_rst_n <= 1'b0;
      cfg_start  <= 1'b0;
      sys_rst_n  <= 1'b0;
      seq_ready  <= 1'b0;
      seq_err    <= 1'b0;
      state_o    <= '0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      r_retry    <= w_retry_next;
      cmos_pwdn  <= (w_next == ST_WAIT_LOCK) || (w_next == ST_PWDN_HOLD) || (w_next == ST_ERR);
      cmos_rst_n <= (w_next == ST_BOOT_WAIT) || (w_next == ST_CONFIG) || (w_next == ST_RUN);
      cfg_start  <= (w_next == ST_CONFIG) && (r_state != ST_CONFIG);
      sys_rst_n  <= (w_next == ST_RUN);
      seq_ready  <= (w_next == ST_RUN);
      seq_err    <= (w_next == ST_ERR);
      state_o    <= w_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmos_pwr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cmos_pwr_seq : directed vectors plus randomized lock/cfg_done      |
// |                   traffic against a phase/duration reference model    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_cmos_pwr_seq;

  localparam int LOCK_FILT = 4;
  localparam int PWDN      = 10;
  localparam int RSTC      = 5;
  localparam int BOOT      = 20;
  localparam int TIMEOUT   = 50;
  localparam int RETRIES   = 2;

  // Output bundle: {pwdn, rst_n, cfg_start, sys_rst_n, ready, err, state[2:0]}
  localparam logic [8:0] WAIT_B  = 9'b100000000;
  localparam logic [8:0] PWDN_B  = 9'b100000001;
  localparam logic [8:0] RST_B   = 9'b000000010;
  localparam logic [8:0] BOOT_B  = 9'b010000011;
  localparam logic [8:0] START_B = 9'b011000100;
  localparam logic [8:0] CFG_B   = 9'b010000100;
  localparam logic [8:0] RUN_B   = 9'b010110101;
  localparam logic [8:0] ERR_B   = 9'b100001110;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       cfg_done = 1'b0;
  logic       cmos_pwdn, cmos_rst_n, cfg_start, sys_rst_n, seq_ready, seq_err;
  logic [2:0] state_o;
  logic [8:0] dut_b;
  logic       chk_en = 1'b0;
  int         n_vec = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  cmos_pwr_seq #(
    .LOCK_FILT_CYC   (LOCK_FILT),
    .PWDN_CYC        (PWDN),
    .RST_CYC         (RSTC),
    .BOOT_CYC        (BOOT),
    .CFG_TIMEOUT_CYC (TIMEOUT),
    .MAX_RETRY       (RETRIES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .cfg_done   (cfg_done),
    .cmos_pwdn  (cmos_pwdn),
    .cmos_rst_n (cmos_rst_n),
    .cfg_start  (cfg_start),
    .sys_rst_n  (sys_rst_n),
    .seq_ready  (seq_ready),
    .seq_err    (seq_err),
    .state_o    (state_o)
  );

  assign dut_b = {cmos_pwdn, cmos_rst_n, cfg_start, sys_rst_n, seq_ready, seq_err, state_o};

  // Reference model: a phase index, cycles spent in it, a lock delay line.
  typedef struct {
    int   phase;
    int   elapsed;
    int   retries;
    logic s0;
    logic s1;
  } mstate_t;

  mstate_t    m = '{phase: 0, elapsed: 0, retries: 0, s0: 1'b0, s1: 1'b0};
  logic [6:0] pwdn_by_phase = 7'b1000011;
  logic [6:0] rstn_by_phase = 7'b0111000;
  logic [6:0] sys_by_phase  = 7'b0100000;

  function automatic int dur(input int p);
    case (p)
      1:       return PWDN;
      2:       return RSTC;
      3:       return BOOT;
      default: return 0;
    endcase
  endfunction

  function automatic mstate_t mstep(input mstate_t cur, input logic lock, input logic done);
    mstate_t n;
    logic    ls;
    n    = cur;
    ls   = cur.s1;
    n.s1 = cur.s0;
    n.s0 = lock;
    if (cur.phase >= 1 && cur.phase <= 5 && !ls) begin
      n.phase   = 0;
      n.elapsed = 0;
    end else if (cur.phase == 0) begin
      n.elapsed = ls ? cur.elapsed + 1 : 0;
      if (n.elapsed == LOCK_FILT) begin
        n.phase   = 1;
        n.elapsed = 0;
      end
    end else if (cur.phase >= 1 && cur.phase <= 3) begin
      n.elapsed = cur.elapsed + 1;
      if (n.elapsed == dur(cur.phase)) begin
        n.phase   = cur.phase + 1;
        n.elapsed = 0;
      end
    end else if (cur.phase == 4) begin
      if (done) begin
        n.phase   = 5;
        n.elapsed = 0;
        n.retries = 0;
      end else begin
        n.elapsed = cur.elapsed + 1;
        if (n.elapsed == TIMEOUT) begin
          n.elapsed = 0;
          if (cur.retries + 1 == RETRIES) begin
            n.phase = 6;
          end else begin
            n.phase   = 2;
            n.retries = cur.retries + 1;
          end
        end
      end
    end
    return n;
  endfunction

  function automatic logic [8:0] expected(input mstate_t cur);
    return {pwdn_by_phase[cur.phase], rstn_by_phase[cur.phase],
            (cur.phase == 4 && cur.elapsed == 0), sys_by_phase[cur.phase],
            (cur.phase == 5), (cur.phase == 6), 3'(cur.phase)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{phase: 0, elapsed: 0, retries: 0, s0: 1'b0, s1: 1'b0};
    else        m <= mstep(m, pll_lock, cfg_done);
  end

  task automatic cmp(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b required %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) cmp("model", dut_b, expected(m));
  end

  task automatic wait_state(input logic [2:0] s, input int lim);
    int n;
    n = 0;
    while (state_o !== s && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (state_o !== s) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_state: state_o=%0d required %0d within %0d cycles", state_o, s, lim);
    end
  endtask

  typedef struct {
    int         cyc;
    logic       done;
    logic [8:0] exp;
  } vec_t;

  vec_t vec[13];

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, state_o=%0d", state_o);
    $fatal(1);
  end

  initial begin
    int idx;
    vec[0]  = '{0,  1'b0, WAIT_B};
    vec[1]  = '{5,  1'b0, WAIT_B};
    vec[2]  = '{6,  1'b0, PWDN_B};
    vec[3]  = '{15, 1'b0, PWDN_B};
    vec[4]  = '{16, 1'b0, RST_B};
    vec[5]  = '{20, 1'b0, RST_B};
    vec[6]  = '{21, 1'b0, BOOT_B};
    vec[7]  = '{40, 1'b0, BOOT_B};
    vec[8]  = '{41, 1'b0, START_B};
    vec[9]  = '{42, 1'b0, CFG_B};
    vec[10] = '{48, 1'b1, CFG_B};
    vec[11] = '{49, 1'b0, RUN_B};
    vec[12] = '{55, 1'b0, RUN_B};

    repeat (3) @(negedge clk);
    cmp("reset_values", dut_b, WAIT_B);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (100) @(negedge clk);
    cmp("no_lock_idle", dut_b, WAIT_B);

    // Full bring-up timed from the lock rising edge.
    pll_lock = 1'b1;
    idx = 0;
    for (int k = 0; k <= 55; k++) begin
      if (k > 0) @(negedge clk);
      cfg_done = 1'b0;
      if (idx < 13 && vec[idx].cyc == k) begin
        cmp($sformatf("vec%0d_k%0d", idx, k), dut_b, vec[idx].exp);
        cfg_done = vec[idx].done;
        idx++;
      end
    end
    cfg_done = 1'b0;

    // Lock loss in RUN: two synchronizer stages, then the state edge.
    pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    cmp("run_before_loss", dut_b, RUN_B);
    @(negedge clk);
    cmp("lock_loss", dut_b, WAIT_B);

    // One-cycle lock glitch while the filter is at 2.
    pll_lock = 1'b1;
    repeat (2) @(negedge clk);
    pll_lock = 1'b0;
    @(negedge clk);
    pll_lock = 1'b1;
    repeat (5) @(negedge clk);
    cmp("glitch_wait", dut_b, WAIT_B);
    @(negedge clk);
    cmp("glitch_pwdn", dut_b, PWDN_B);

    // Two config timeouts without cfg_done end in ERR.
    wait_state(3'd4, 200);
    cmp("cfg_start_1", dut_b, START_B);
    repeat (49) @(negedge clk);
    cmp("cfg_last_cycle", dut_b, CFG_B);
    @(negedge clk);
    cmp("timeout_rereset", dut_b, RST_B);
    repeat (25) @(negedge clk);
    cmp("cfg_start_2", dut_b, START_B);
    repeat (50) @(negedge clk);
    cmp("err_entry", dut_b, ERR_B);
    pll_lock = 1'b0;
    repeat (10) @(negedge clk);
    pll_lock = 1'b1;
    repeat (10) @(negedge clk);
    cmp("err_sticky", dut_b, ERR_B);

    // Asynchronous reset in the middle of BOOT_WAIT.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    wait_state(3'd3, 200);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 cmp("async_reset", dut_b, WAIT_B);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized lock/cfg_done traffic with occasional async resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (pll_lock) begin
        if ($urandom_range(0, 299) == 0) pll_lock = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        pll_lock = 1'b1;
      end
      cfg_done = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 799) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
